// File: rtl/addr_calc_pkg.sv
// Shared definitions for the address-calculation path: FSM state encoding and
// default counter widths used by the address generator and the length counter.
package addr_calc_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/xfer_length_counter_if.sv
// Control/status bundle between the router FSM / address generator (master)
// and the transfer-length counter (slave).
interface xfer_length_counter_if #(
  parameter int unsigned CNT_W  = addr_calc_pkg::CNT_W_DEF,
  parameter int unsigned STEP_W = addr_calc_pkg::STEP_W_DEF
);

  logic              start;
  logic [CNT_W-1:0]  filesize;
  logic [STEP_W-1:0] step;
  logic              advance;
  logic              abort;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  remaining;
  logic              last;
  logic              done;
  logic              aborted;
  logic              err;

  modport master (
    output start, filesize, step, advance, abort,
    input  busy, count, remaining, last, done, aborted, err
  );

  modport slave (
    input  start, filesize, step, advance, abort,
    output busy, count, remaining, last, done, aborted, err
  );

endinterface

// File: rtl/sat_step_adder.sv
// count + step computed one bit wider than count, compared against limit and
// clamped to it, so the counter can never wrap past the file size.
module sat_step_adder #(
  parameter int unsigned CNT_W  = addr_calc_pkg::CNT_W_DEF,
  parameter int unsigned STEP_W = addr_calc_pkg::STEP_W_DEF
) (
  input  logic [CNT_W-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [CNT_W-1:0]  limit,
  output logic [CNT_W-1:0]  next,
  output logic              hit
);

  logic [CNT_W:0] sum;

  always_comb begin
    sum  = {1'b0, count} + (CNT_W+1)'(step);
    hit  = sum >= {1'b0, limit};
    next = hit ? limit : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/xfer_length_counter.sv
// Transfer-length counter: paces one file transfer by counting accepted beats of
// step_q units against a latched size, with start/done handshake, abort and err.
module xfer_length_counter #(
  parameter int unsigned CNT_W  = addr_calc_pkg::CNT_W_DEF,
  parameter int unsigned STEP_W = addr_calc_pkg::STEP_W_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  xfer_length_counter_if.slave bus
);

  import addr_calc_pkg::*;

  xfer_state_e       state_q, state_d;
  logic [CNT_W-1:0]  size_q, size_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              aborted_q, aborted_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  sum_next;
  logic              sum_hit;
  logic [CNT_W-1:0]  remaining;

  sat_step_adder #(
    .CNT_W  (CNT_W),
    .STEP_W (STEP_W)
  ) u_adder (
    .count (count_q),
    .step  (step_q),
    .limit (size_q),
    .next  (sum_next),
    .hit   (sum_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q    <= '0;
      step_q    <= '0;
      count_q   <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      size_q    <= size_d;
      step_q    <= step_d;
      count_q   <= count_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    step_d    = step_q;
    count_d   = count_q;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.filesize == '0) begin
            // Zero-length file: complete without entering RUN.
            state_d = ST_DONE;
            size_d  = '0;
            step_d  = bus.step;
            count_d = '0;
          end else if (bus.step == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            size_d  = bus.filesize;
            step_d  = bus.step;
            count_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (bus.advance) begin
          count_d = sum_next;
          if (sum_hit) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    remaining     = size_q - count_q;
    bus.remaining = remaining;
    bus.count     = count_q;
    bus.busy      = state_q != ST_IDLE;
    bus.done      = state_q == ST_DONE;
    bus.last      = (state_q == ST_RUN) && (remaining <= CNT_W'(step_q));
    bus.aborted   = aborted_q;
    bus.err       = err_q;
  end

endmodule
